rule110_host_ctrl: RTL and testbench

RULE110_HOST_CTRL -- requirements
Module: rule110_host_ctrl

---
 rtl/rule110_host_ctrl.sv | 176 +++++++++++++++++
 tb/tb_rule110_host_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rule110_host_ctrl.sv
// Host-side controller for a block-addressed Rule 110 automaton device.
// It accepts LOAD / RUN / DUMP / NOP commands, streams block data in and out,
// and gates the device's generation clock through an active-low halt line.
module rule110_host_ctrl #(
  parameter int NUM_BLOCKS = 32,
  parameter int ADDR_W     = 6,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_arg,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  output logic              rd_valid,
  output logic              rd_last,
  input  logic              rd_ready,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              dev_we_n,
  output logic              dev_halt_n,
  output logic [ADDR_W-1:0] dev_addr,
  output logic [7:0]        dev_data,
  input  logic [7:0]        dev_q
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LD_WAIT = 3'd1;
  localparam logic [2:0] S_LD_WR   = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_RD_ADDR = 3'd4;
  localparam logic [2:0] S_RD_WAIT = 3'd5;
  localparam logic [2:0] S_RD_OUT  = 3'd6;
  localparam logic [2:0] S_FIN     = 3'd7;

  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;

  localparam logic [ADDR_W-1:0] LAST_BLK = ADDR_W'(NUM_BLOCKS - 1);

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_blk;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we_n;
  logic              r_halt_n;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_data;
  logic              r_rd_valid;
  logic              r_rd_last;
  logic [7:0]        r_rd_data;
  logic              r_done;

  logic w_cmd_fire;
  logic w_wr_fire;
  logic w_rd_fire;
  logic w_last_blk;

  // Handshake readiness depends only on state, and is forced low during reset.
  assign cmd_ready = !reset && (r_state == S_IDLE);
  assign wr_ready  = !reset && (r_state == S_LD_WAIT);
  assign busy      = !reset && (r_state != S_IDLE);

  assign w_cmd_fire = cmd_valid && cmd_ready;
  assign w_wr_fire  = wr_valid && wr_ready;
  assign w_rd_fire  = r_rd_valid && rd_ready && (r_state == S_RD_OUT);
  assign w_last_blk = (r_blk == LAST_BLK);

  assign dev_we_n   = r_we_n;
  assign dev_halt_n = r_halt_n;
  assign dev_addr   = r_addr;
  assign dev_data   = r_data;
  assign rd_valid   = r_rd_valid;
  assign rd_last    = r_rd_last;
  assign rd_data    = r_rd_data;
  assign done       = r_done;

  // Command sequencer: every device-facing output is a register set here.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_blk      <= '0;
      r_cnt      <= '0;
      r_we_n     <= 1'b1;
      r_halt_n   <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
      r_rd_valid <= 1'b0;
      r_rd_last  <= 1'b0;
      r_rd_data  <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_cmd_fire) begin
            r_cnt <= cmd_arg;
            r_blk <= '0;
            case (cmd_op)
              OP_LOAD: r_state <= S_LD_WAIT;
              OP_RUN:  r_state <= S_RUN;
              OP_DUMP: begin
                r_addr  <= '0;
                r_state <= S_RD_ADDR;
              end
              default: begin
                r_done  <= 1'b1;
                r_state <= S_FIN;
              end
            endcase
          end
        end
        S_LD_WAIT: begin
          if (w_wr_fire) begin
            r_addr  <= r_blk;
            r_data  <= wr_data;
            r_we_n  <= 1'b0;
            r_state <= S_LD_WR;
          end
        end
        S_LD_WR: begin
          r_we_n <= 1'b1;
          if (w_last_blk) begin
            r_blk   <= '0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_blk   <= r_blk + ADDR_W'(1);
            r_state <= S_LD_WAIT;
          end
        end
        // First RUN cycle only inspects the latched count, so halt_n is high
        // for exactly K cycles and a zero count never raises it.
        S_RUN: begin
          if (r_cnt == '0) begin
            r_halt_n <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_FIN;
          end else begin
            r_halt_n <= 1'b1;
            r_cnt    <= r_cnt - CNT_W'(1);
          end
        end
        S_RD_ADDR: r_state <= S_RD_WAIT;
        S_RD_WAIT: begin
          r_rd_data  <= dev_q;
          r_rd_valid <= 1'b1;
          r_rd_last  <= w_last_blk;
          r_state    <= S_RD_OUT;
        end
        S_RD_OUT: begin
          if (w_rd_fire) begin
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            if (w_last_blk) begin
              r_blk   <= '0;
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_blk   <= r_blk + ADDR_W'(1);
              r_addr  <= r_blk + ADDR_W'(1);
              r_state <= S_RD_ADDR;
            end
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rule110_host_ctrl.sv
// Self-checking bench for rule110_host_ctrl with a behavioural automaton device.
module tb_rule110_host_ctrl;
  localparam int NB = 32;
  localparam logic [1:0] OP_LOAD = 2'd0;
  localparam logic [1:0] OP_RUN  = 2'd1;
  localparam logic [1:0] OP_DUMP = 2'd2;
  localparam logic [1:0] OP_NOP  = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'd0;
  logic [15:0] cmd_arg = 16'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [7:0]  wr_data = 8'd0;
  logic        rd_valid, rd_last;
  logic        rd_ready = 1'b0;
  logic [7:0]  rd_data;
  logic        busy, done, dev_we_n, dev_halt_n;
  logic [5:0]  dev_addr;
  logic [7:0]  dev_data, dev_q;

  rule110_host_ctrl #(.NUM_BLOCKS(32), .ADDR_W(6), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready), .rd_data(rd_data),
    .busy(busy), .done(done),
    .dev_we_n(dev_we_n), .dev_halt_n(dev_halt_n), .dev_addr(dev_addr), .dev_data(dev_data),
    .dev_q(dev_q)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One Rule 110 generation; cell i is bit i, cells outside the array are 0,
  // and the left neighbour of cell i is cell i-1.
  function automatic logic [255:0] gen(input logic [255:0] c);
    logic [257:0] p;
    logic [255:0] n;
    logic [7:0]   rule;
    logic [2:0]   nb;
    rule = 8'd110;
    p = {1'b0, c, 1'b0};
    n = '0;
    for (int i = 0; i < 256; i++) begin
      nb = {p[i], p[i+1], p[i+2]};
      n[i] = rule[nb];
    end
    return n;
  endfunction

  // Device model: 32 blocks of 8 cells, write has priority, advances when not halted.
  logic [255:0] dev_cells = '0;
  always @(posedge clk) begin
    if (dev_we_n === 1'b0) begin
      if (dev_addr < 6'd32) dev_cells[{dev_addr, 3'b000} +: 8] <= dev_data;
    end else if (dev_halt_n === 1'b1) begin
      dev_cells <= gen(dev_cells);
    end
  end
  assign dev_q = (dev_addr < 6'd32) ? dev_cells[{dev_addr, 3'b000} +: 8] : 8'h00;

  // Reference contents derived from issued commands only.
  logic [255:0] ref_cells = '0;

  typedef struct { logic [1:0] op; logic [15:0] arg; } cmd_t;
  typedef struct { logic [1:0] op; logic [15:0] arg; int kind; bit wr_rnd; bit rd_rnd; int lat; } vec_t;

  cmd_t        cmd_q[$];
  int          cyc = 0;
  int          acc_cyc[$];
  int          done_cyc[$];
  logic [13:0] wq[$];
  logic [8:0]  rq[$];
  int          halt_cnt = 0;
  bit          wr_rand = 0, rd_rand = 0;
  logic [7:0]  load_bytes[NB];
  int          wr_idx = 0;
  bit          prev_we_low = 0, prev_rd_hold = 0;
  logic [7:0]  prev_rd_data = '0;

  // One clock: sample outputs at the falling edge, then drive inputs for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (dev_we_n === 1'b0) begin
      chk("we_pulse_width", 64'(prev_we_low), 64'd0);
      wq.push_back({dev_addr, dev_data});
    end
    prev_we_low = (dev_we_n === 1'b0);
    if (dev_halt_n === 1'b1) halt_cnt++;
    if (done === 1'b1) done_cyc.push_back(cyc);
    if (dev_addr >= 6'd32) chk("addr_range", 64'(dev_addr), 64'd31);
    if (prev_rd_hold) begin
      chk("rd_hold_valid", 64'(rd_valid), 64'd1);
      chk("rd_hold_data", 64'(rd_data), 64'(prev_rd_data));
    end
    if (cmd_q.size() > 0) begin
      cmd_valid = 1'b1;
      cmd_op    = cmd_q[0].op;
      cmd_arg   = cmd_q[0].arg;
    end else begin
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom);
      cmd_arg   = 16'($urandom);
    end
    wr_valid = wr_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    wr_data  = wr_valid ? load_bytes[wr_idx] : 8'($urandom);
    rd_ready = rd_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    if (cmd_valid && (cmd_ready === 1'b1)) begin
      acc_cyc.push_back(cyc);
      void'(cmd_q.pop_front());
    end
    if (wr_valid && (wr_ready === 1'b1) && (wr_idx < NB - 1)) wr_idx++;
    if ((rd_valid === 1'b1) && rd_ready) rq.push_back({rd_last, rd_data});
    prev_rd_hold = (rd_valid === 1'b1) && !rd_ready;
    prev_rd_data = rd_data;
  endtask

  task automatic clear_obs();
    acc_cyc.delete();
    done_cyc.delete();
    wq.delete();
    rq.delete();
    halt_cnt = 0;
  endtask

  task automatic advance_ref(input int gens);
    for (int g = 0; g < gens; g++) ref_cells = gen(ref_cells);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int n;
    int exp_we, exp_rd, exp_halt;
    if (v.op == OP_LOAD) begin
      for (int b = 0; b < NB; b++) begin
        case (v.kind)
          0:       load_bytes[b] = 8'(b);
          1:       load_bytes[b] = (b == 0) ? 8'h02 : 8'h00;
          default: load_bytes[b] = 8'($urandom);
        endcase
      end
      wr_idx = 0;
    end
    wr_rand = v.wr_rnd;
    rd_rand = v.rd_rnd;
    clear_obs();
    cmd_q.push_back('{v.op, v.arg});
    n = 0;
    while (done_cyc.size() == 0 && n < 3000) begin
      tick();
      n++;
    end
    for (int i = 0; i < 3; i++) tick();
    exp_we   = (v.op == OP_LOAD) ? NB : 0;
    exp_rd   = (v.op == OP_DUMP) ? NB : 0;
    exp_halt = (v.op == OP_RUN) ? int'(v.arg) : 0;
    chk({tag, "_accepts"}, 64'(acc_cyc.size()), 64'd1);
    chk({tag, "_done_pulses"}, 64'(done_cyc.size()), 64'd1);
    if (v.lat >= 0 && acc_cyc.size() > 0 && done_cyc.size() > 0)
      chk({tag, "_latency"}, 64'(done_cyc[0] - acc_cyc[0]), 64'(v.lat));
    chk({tag, "_halt_cycles"}, 64'(halt_cnt), 64'(exp_halt));
    chk({tag, "_we_pulses"}, 64'(wq.size()), 64'(exp_we));
    for (int b = 0; b < wq.size() && b < exp_we; b++) begin
      chk($sformatf("%s_we_addr%0d", tag, b), 64'(wq[b][13:8]), 64'(b));
      chk($sformatf("%s_we_data%0d", tag, b), 64'(wq[b][7:0]), 64'(load_bytes[b]));
    end
    chk({tag, "_rd_count"}, 64'(rq.size()), 64'(exp_rd));
    for (int b = 0; b < rq.size() && b < exp_rd; b++) begin
      chk($sformatf("%s_rd_data%0d", tag, b), 64'(rq[b][7:0]), 64'(ref_cells[b*8 +: 8]));
      chk($sformatf("%s_rd_last%0d", tag, b), 64'(rq[b][8]), 64'(b == NB - 1));
    end
    if (v.op == OP_LOAD)
      for (int b = 0; b < NB; b++) ref_cells[b*8 +: 8] = load_bytes[b];
    if (v.op == OP_RUN) advance_ref(int'(v.arg));
    chk({tag, "_device_state"}, 64'(dev_cells == ref_cells), 64'd1);
    chk({tag, "_idle_ready"}, 64'({busy, cmd_ready}), 64'b01);
  endtask

  vec_t tbl[13];
  int   k_rand;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    k_rand = $urandom_range(1, 30);
    tbl[0]  = '{OP_LOAD, 16'd0,         0, 1'b0, 1'b0, 65};
    tbl[1]  = '{OP_DUMP, 16'd0,         0, 1'b0, 1'b0, 97};
    tbl[2]  = '{OP_RUN,  16'd5,         0, 1'b0, 1'b0, 7};
    tbl[3]  = '{OP_DUMP, 16'd7,         0, 1'b0, 1'b1, -1};
    tbl[4]  = '{OP_RUN,  16'd0,         0, 1'b0, 1'b0, 2};
    tbl[5]  = '{OP_NOP,  16'd9,         0, 1'b0, 1'b0, 1};
    tbl[6]  = '{OP_LOAD, 16'd3,         1, 1'b0, 1'b0, 65};
    tbl[7]  = '{OP_DUMP, 16'd0,         0, 1'b0, 1'b0, 97};
    tbl[8]  = '{OP_RUN,  16'(k_rand),   0, 1'b0, 1'b0, k_rand + 2};
    tbl[9]  = '{OP_DUMP, 16'd0,         0, 1'b0, 1'b1, -1};
    tbl[10] = '{OP_LOAD, 16'd0,         2, 1'b1, 1'b0, -1};
    tbl[11] = '{OP_RUN,  16'd13,        0, 1'b0, 1'b0, 15};
    tbl[12] = '{OP_DUMP, 16'd0,         0, 1'b0, 1'b1, -1};

    // Reset state
    reset = 1'b1;
    tick();
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_outputs", 64'({dev_we_n, dev_halt_n, dev_addr, dev_data, rd_valid, rd_last, rd_data, done}),
        64'({1'b1, 1'b0, 6'd0, 8'd0, 1'b0, 1'b0, 8'd0, 1'b0}));
    tick();
    reset = 1'b0;
    tick();
    chk("post_rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);

    for (int i = 0; i < 13; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of a long RUN
    clear_obs();
    cmd_q.push_back('{OP_RUN, 16'd100});
    for (int i = 0; i < 10 && acc_cyc.size() == 0; i++) tick();
    chk("midrst_accept", 64'(acc_cyc.size()), 64'd1);
    for (int i = 0; i < 40; i++) tick();
    chk("midrst_halt_before", 64'(dev_halt_n), 64'd1);
    reset = 1'b1;
    tick();
    chk("midrst_halt_after", 64'(dev_halt_n), 64'd0);
    chk("midrst_we_n", 64'(dev_we_n), 64'd1);
    chk("midrst_busy", 64'(busy), 64'd0);
    reset = 1'b0;
    tick();
    chk("midrst_cmd_ready", 64'(cmd_ready), 64'd1);
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_done", 64'(done_cyc.size()), 64'd0);
    chk("midrst_halt_cycles", 64'(halt_cnt), 64'd39);
    advance_ref(39);
    run_vec('{OP_DUMP, 16'd0, 0, 1'b0, 1'b1, -1}, "midrst_dump");

    // Second command held valid while the first is busy
    clear_obs();
    cmd_q.push_back('{OP_RUN, 16'd10});
    cmd_q.push_back('{OP_NOP, 16'd0});
    for (int i = 0; i < 200 && done_cyc.size() < 2; i++) tick();
    for (int i = 0; i < 3; i++) tick();
    chk("hold_accepts", 64'(acc_cyc.size()), 64'd2);
    chk("hold_dones", 64'(done_cyc.size()), 64'd2);
    chk("hold_halt_cycles", 64'(halt_cnt), 64'd10);
    if (acc_cyc.size() == 2 && done_cyc.size() == 2) begin
      chk("hold_run_latency", 64'(done_cyc[0] - acc_cyc[0]), 64'd12);
      chk("hold_second_accept", 64'(acc_cyc[1]), 64'(done_cyc[0] + 1));
      chk("hold_nop_latency", 64'(done_cyc[1] - acc_cyc[1]), 64'd1);
    end
    advance_ref(10);
    run_vec('{OP_DUMP, 16'd0, 0, 1'b0, 1'b0, 97}, "final_dump");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
